// File: rtl/biu_constants_pkg.sv
// Shared BIU encodings used by the CPU bus interface and its observers.
package biu_constants_pkg;

  typedef enum logic [1:0] {
    BIU_SZ_BYTE  = 2'd0,
    BIU_SZ_HALF  = 2'd1,
    BIU_SZ_WORD  = 2'd2,
    BIU_SZ_DWORD = 2'd3
  } biu_size_t;

endpackage

// File: rtl/biu_tracker_pkg.sv
// Types and helpers for the BIU access tracker.
// pend_t / rec_t describe the default 32-bit / 16-bit-timestamp configuration.
package biu_tracker_pkg;
  import biu_constants_pkg::*;

  localparam int unsigned DEF_XLEN    = 32;
  localparam int unsigned DEF_TS_BITS = 16;
  // Window compares run at this width (+1 carry bit); XLEN must not exceed it.
  localparam int unsigned WIN_CMP_W   = 64;

  typedef struct packed {
    logic [DEF_XLEN-1:0]    adr;
    logic [DEF_XLEN-1:0]    data;
    logic                   we;
    biu_size_t              size;
    logic [DEF_XLEN-1:0]    sp;
    logic [DEF_XLEN-1:0]    ra;
    logic [DEF_TS_BITS-1:0] ts;
  } pend_t;

  typedef struct packed {
    logic [DEF_XLEN-1:0]    adr;
    logic [DEF_XLEN-1:0]    data;
    logic [DEF_XLEN-1:0]    sp;
    logic [DEF_XLEN-1:0]    ra;
    logic                   we;
    logic                   err;
    biu_size_t              size;
    logic [DEF_TS_BITS-1:0] lat;
  } rec_t;

  // Carry bit on the window end keeps a window that ends at the top of memory from wrapping.
  function automatic logic in_window(input logic [WIN_CMP_W-1:0] adr,
                                     input logic [WIN_CMP_W-1:0] base,
                                     input logic [WIN_CMP_W-1:0] range);
    logic [WIN_CMP_W:0] w_end;
    w_end = {1'b0, base} + {1'b0, range};
    return (range != '0) && (adr >= base) && ({1'b0, adr} < w_end);
  endfunction

endpackage

// File: rtl/biu_access_tracker_if.sv
// Snooped BIU request/response signals plus the record stream and statistics.
interface biu_access_tracker_if
  import biu_constants_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned TS_BITS  = 16,
  parameter int unsigned CNT_BITS = 32,
  parameter int unsigned LVL_BITS = 3
);

  logic                req_i;
  logic [XLEN-1:0]     adr_i;
  logic [XLEN-1:0]     d_i;
  logic                we_i;
  biu_size_t           size_i;
  logic [XLEN-1:0]     sp_i;
  logic [XLEN-1:0]     ra_i;
  logic                ack_i;
  logic                err_i;
  logic [XLEN-1:0]     q_i;
  logic                clr_i;

  logic                rec_valid_o;
  logic                rec_ready_i;
  logic [XLEN-1:0]     rec_adr_o;
  logic [XLEN-1:0]     rec_data_o;
  logic [XLEN-1:0]     rec_sp_o;
  logic [XLEN-1:0]     rec_ra_o;
  logic                rec_we_o;
  logic                rec_err_o;
  biu_size_t           rec_size_o;
  logic [TS_BITS-1:0]  rec_lat_o;

  logic [CNT_BITS-1:0] cnt_rd_o;
  logic [CNT_BITS-1:0] cnt_wr_o;
  logic [CNT_BITS-1:0] cnt_err_o;
  logic [CNT_BITS-1:0] cnt_drop_o;
  logic [LVL_BITS-1:0] outstanding_o;
  logic                overflow_o;
  logic                underflow_o;

  modport slave (
    input  req_i, adr_i, d_i, we_i, size_i, sp_i, ra_i, ack_i, err_i, q_i, clr_i, rec_ready_i,
    output rec_valid_o, rec_adr_o, rec_data_o, rec_sp_o, rec_ra_o, rec_we_o, rec_err_o,
           rec_size_o, rec_lat_o, cnt_rd_o, cnt_wr_o, cnt_err_o, cnt_drop_o,
           outstanding_o, overflow_o, underflow_o
  );

  modport master (
    output req_i, adr_i, d_i, we_i, size_i, sp_i, ra_i, ack_i, err_i, q_i, clr_i, rec_ready_i,
    input  rec_valid_o, rec_adr_o, rec_data_o, rec_sp_o, rec_ra_o, rec_we_o, rec_err_o,
           rec_size_o, rec_lat_o, cnt_rd_o, cnt_wr_o, cnt_err_o, cnt_drop_o,
           outstanding_o, overflow_o, underflow_o
  );

endinterface

// File: rtl/biu_tracker_fifo.sv
// In-order pending-request FIFO; caller qualifies push/pop against full/empty.
module biu_tracker_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic [31:0]
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  T                       din_i,
  input  logic                   pop_i,
  output T                       head_c,
  output logic                   full_c,
  output logic                   empty_c,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  logic [AW:0] r_level;
  T            r_mem [DEPTH];

  // Storage carries no reset; only the pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wr[AW-1:0]] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (push_i) r_wr <= r_wr + (AW+1)'(1);
      if (pop_i)  r_rd <= r_rd + (AW+1)'(1);
      case ({push_i, pop_i})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Extra pointer bit separates full (wrap bits differ) from empty (identical).
  assign full_c  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign empty_c = (r_wr == r_rd);
  assign head_c  = r_mem[r_rd[AW-1:0]];
  assign level_o = r_level;

endmodule

// File: rtl/biu_access_tracker.sv
// Snoops BIU requests/responses, pairs them in order and streams completed-access
// records for windowed addresses, with saturating statistics and sticky error flags.
module biu_access_tracker
  import biu_constants_pkg::*;
  import biu_tracker_pkg::*;
#(
  parameter int unsigned          XLEN      = 32,
  parameter int unsigned          DEPTH     = 4,
  parameter int unsigned          NWIN      = 2,
  parameter logic [NWIN*XLEN-1:0] WIN_BASE  = '0,
  parameter logic [NWIN*XLEN-1:0] WIN_RANGE = {NWIN{XLEN'(32'h4000)}},
  parameter int unsigned          TS_BITS   = 16,
  parameter int unsigned          CNT_BITS  = 32
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  biu_access_tracker_if.slave  bus
);

  localparam int unsigned LVL_BITS = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0]    adr;
    logic [XLEN-1:0]    data;
    logic               we;
    biu_size_t          size;
    logic [XLEN-1:0]    sp;
    logic [XLEN-1:0]    ra;
    logic [TS_BITS-1:0] ts;
  } pend_w_t;

  typedef struct packed {
    logic [XLEN-1:0]    adr;
    logic [XLEN-1:0]    data;
    logic [XLEN-1:0]    sp;
    logic [XLEN-1:0]    ra;
    logic               we;
    logic               err;
    biu_size_t          size;
    logic [TS_BITS-1:0] lat;
  } rec_w_t;

  function automatic logic [CNT_BITS-1:0] sat_add(input logic [CNT_BITS-1:0] a,
                                                  input logic [1:0]          inc);
    logic [CNT_BITS:0] s;
    s = {1'b0, a} + (CNT_BITS+1)'(inc);
    return s[CNT_BITS] ? '1 : s[CNT_BITS-1:0];
  endfunction

  logic [TS_BITS-1:0]  r_ts;
  logic                r_rec_valid;
  rec_w_t              r_rec;
  logic [CNT_BITS-1:0] r_cnt_rd;
  logic [CNT_BITS-1:0] r_cnt_wr;
  logic [CNT_BITS-1:0] r_cnt_err;
  logic [CNT_BITS-1:0] r_cnt_drop;
  logic                r_overflow;
  logic                r_underflow;

  pend_w_t             w_push_data;
  pend_w_t             w_head;
  logic                w_full;
  logic                w_empty;
  logic [LVL_BITS-1:0] w_level;
  logic                w_resp;
  logic                w_pop;
  logic                w_push;
  logic                w_drop_req;
  logic                w_under;
  logic                w_match;
  logic                w_new;
  logic                w_rec_load;
  logic                w_rec_drop;
  rec_w_t              w_rec_next;
  logic                w_inc_rd;
  logic                w_inc_wr;
  logic                w_inc_err;
  logic [1:0]          w_inc_drop;

  assign w_push_data = '{adr: bus.adr_i, data: bus.d_i, we: bus.we_i, size: bus.size_i,
                         sp: bus.sp_i, ra: bus.ra_i, ts: r_ts};

  biu_tracker_fifo #(
    .DEPTH (DEPTH),
    .T     (pend_w_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .din_i   (w_push_data),
    .pop_i   (w_pop),
    .head_c  (w_head),
    .full_c  (w_full),
    .empty_c (w_empty),
    .level_o (w_level)
  );

  // A response always retires the oldest entry; a same-cycle request cannot be the one it retires.
  always_comb begin
    w_resp     = bus.ack_i | bus.err_i;
    w_pop      = w_resp & ~w_empty;
    w_under    = w_resp & w_empty;
    w_push     = bus.req_i & (~w_full | w_pop);
    w_drop_req = bus.req_i & w_full & ~w_pop;
  end

  always_comb begin
    w_match = 1'b0;
    for (int i = 0; i < NWIN; i++) begin
      w_match |= in_window(WIN_CMP_W'(w_head.adr),
                           WIN_CMP_W'(WIN_BASE[i*XLEN +: XLEN]),
                           WIN_CMP_W'(WIN_RANGE[i*XLEN +: XLEN]));
    end
  end

  // Record contents and slot arbitration for the access retiring this cycle.
  always_comb begin
    w_rec_next.adr  = w_head.adr;
    w_rec_next.data = w_head.we ? w_head.data : bus.q_i;
    w_rec_next.sp   = w_head.sp;
    w_rec_next.ra   = w_head.ra;
    w_rec_next.we   = w_head.we;
    w_rec_next.err  = bus.err_i;
    w_rec_next.size = w_head.size;
    w_rec_next.lat  = r_ts - w_head.ts;

    w_new      = w_pop & w_match;
    w_rec_load = w_new & (~r_rec_valid | bus.rec_ready_i);
    w_rec_drop = w_new & r_rec_valid & ~bus.rec_ready_i;

    w_inc_rd   = w_new & ~bus.err_i & ~w_head.we;
    w_inc_wr   = w_new & ~bus.err_i &  w_head.we;
    w_inc_err  = w_new &  bus.err_i;
    w_inc_drop = 2'(w_drop_req) + 2'(w_rec_drop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_ts <= '0;
    else         r_ts <= r_ts + TS_BITS'(1);
  end

  // Single-entry output slot: a held record is never overwritten while stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rec_valid <= 1'b0;
      r_rec       <= '0;
    end else if (w_rec_load) begin
      r_rec_valid <= 1'b1;
      r_rec       <= w_rec_next;
    end else if (bus.rec_ready_i) begin
      r_rec_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt_rd    <= '0;
      r_cnt_wr    <= '0;
      r_cnt_err   <= '0;
      r_cnt_drop  <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.clr_i) begin
      r_cnt_rd    <= '0;
      r_cnt_wr    <= '0;
      r_cnt_err   <= '0;
      r_cnt_drop  <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_cnt_rd    <= sat_add(r_cnt_rd,  {1'b0, w_inc_rd});
      r_cnt_wr    <= sat_add(r_cnt_wr,  {1'b0, w_inc_wr});
      r_cnt_err   <= sat_add(r_cnt_err, {1'b0, w_inc_err});
      r_cnt_drop  <= sat_add(r_cnt_drop, w_inc_drop);
      r_overflow  <= r_overflow  | w_drop_req;
      r_underflow <= r_underflow | w_under;
    end
  end

  assign bus.rec_valid_o   = r_rec_valid;
  assign bus.rec_adr_o     = r_rec.adr;
  assign bus.rec_data_o    = r_rec.data;
  assign bus.rec_sp_o      = r_rec.sp;
  assign bus.rec_ra_o      = r_rec.ra;
  assign bus.rec_we_o      = r_rec.we;
  assign bus.rec_err_o     = r_rec.err;
  assign bus.rec_size_o    = r_rec.size;
  assign bus.rec_lat_o     = r_rec.lat;
  assign bus.cnt_rd_o      = r_cnt_rd;
  assign bus.cnt_wr_o      = r_cnt_wr;
  assign bus.cnt_err_o     = r_cnt_err;
  assign bus.cnt_drop_o    = r_cnt_drop;
  assign bus.outstanding_o = w_level;
  assign bus.overflow_o    = r_overflow;
  assign bus.underflow_o   = r_underflow;

endmodule

// File: tb/tb_biu_access_tracker.sv
// Bench for biu_access_tracker: directed scenarios plus random traffic, all
// checked every cycle against a queue-based model of the access tracker.
module tb_biu_access_tracker;
  import biu_constants_pkg::*;
  import biu_tracker_pkg::*;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned TS_BITS  = 16;
  localparam int unsigned CNT_BITS = 4;
  localparam int unsigned LVL_BITS = 3;
  localparam int unsigned CMAX     = 15;
  // Window 0: [0, 0x4000); window 1: [0xFFFF_F000, 2^32).
  localparam logic [63:0] WB = {32'hFFFF_F000, 32'h0000_0000};
  localparam logic [63:0] WR = {32'h0000_1000, 32'h0000_4000};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  biu_access_tracker_if #(.XLEN(XLEN), .TS_BITS(TS_BITS), .CNT_BITS(CNT_BITS),
                          .LVL_BITS(LVL_BITS)) bus ();

  biu_access_tracker #(
    .XLEN(XLEN), .DEPTH(DEPTH), .NWIN(2), .WIN_BASE(WB), .WIN_RANGE(WR),
    .TS_BITS(TS_BITS), .CNT_BITS(CNT_BITS)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;
  bit          started  = 1'b0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  pend_t       m_q[$];
  rec_t        m_rec;
  logic        m_valid;
  int unsigned m_rd, m_wr, m_err, m_drop;
  logic        m_ovf, m_unf;
  int unsigned m_cyc = 0;

  function automatic bit win_hit(input logic [31:0] a);
    longint unsigned base [2] = '{64'h0, 64'hFFFF_F000};
    longint unsigned size [2] = '{64'h4000, 64'h1000};
    for (int i = 0; i < 2; i++)
      if (size[i] != 0 && longint'(a) >= base[i] && longint'(a) < base[i] + size[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int unsigned sat(input int unsigned v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  always @(posedge clk) begin
    pend_t       e;
    rec_t        nr;
    bit          nrec;
    int unsigned ndrop;
    nrec  = 1'b0;
    ndrop = 0;
    nr    = '0;
    if (!rst_n) begin
      m_q.delete();
      m_valid = 1'b0; m_rec = '0;
      m_rd = 0; m_wr = 0; m_err = 0; m_drop = 0;
      m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      if (bus.ack_i || bus.err_i) begin
        if (m_q.size() == 0) m_unf = 1'b1;
        else begin
          e = m_q.pop_front();
          if (win_hit(e.adr)) begin
            nrec = 1'b1;
            nr.adr = e.adr; nr.sp = e.sp; nr.ra = e.ra; nr.we = e.we; nr.size = e.size;
            nr.data = e.we ? e.data : bus.q_i;
            nr.err  = bus.err_i;
            nr.lat  = TS_BITS'(m_cyc) - e.ts;
            if (bus.err_i)  m_err = sat(m_err + 1);
            else if (e.we)  m_wr  = sat(m_wr + 1);
            else            m_rd  = sat(m_rd + 1);
          end
        end
      end
      if (bus.req_i) begin
        if (m_q.size() < DEPTH)
          m_q.push_back('{adr: bus.adr_i, data: bus.d_i, we: bus.we_i, size: bus.size_i,
                          sp: bus.sp_i, ra: bus.ra_i, ts: TS_BITS'(m_cyc)});
        else begin
          ndrop++;
          m_ovf = 1'b1;
        end
      end
      if (nrec) begin
        if (m_valid && !bus.rec_ready_i) ndrop++;
        else begin m_rec = nr; m_valid = 1'b1; end
      end else if (bus.rec_ready_i) m_valid = 1'b0;
      m_drop = sat(m_drop + ndrop);
      if (bus.clr_i) begin
        m_rd = 0; m_wr = 0; m_err = 0; m_drop = 0; m_ovf = 1'b0; m_unf = 1'b0;
      end
    end
    m_cyc++;
    #1;
    if (started) begin
      cmp("rec_valid",   64'(bus.rec_valid_o),   64'(m_valid));
      cmp("outstanding", 64'(bus.outstanding_o), 64'(m_q.size()));
      cmp("cnt_rd",      64'(bus.cnt_rd_o),      64'(m_rd));
      cmp("cnt_wr",      64'(bus.cnt_wr_o),      64'(m_wr));
      cmp("cnt_err",     64'(bus.cnt_err_o),     64'(m_err));
      cmp("cnt_drop",    64'(bus.cnt_drop_o),    64'(m_drop));
      cmp("overflow",    64'(bus.overflow_o),    64'(m_ovf));
      cmp("underflow",   64'(bus.underflow_o),   64'(m_unf));
      if (m_valid) begin
        cmp("rec_adr",  64'(bus.rec_adr_o),  64'(m_rec.adr));
        cmp("rec_data", 64'(bus.rec_data_o), 64'(m_rec.data));
        cmp("rec_sp",   64'(bus.rec_sp_o),   64'(m_rec.sp));
        cmp("rec_ra",   64'(bus.rec_ra_o),   64'(m_rec.ra));
        cmp("rec_we",   64'(bus.rec_we_o),   64'(m_rec.we));
        cmp("rec_err",  64'(bus.rec_err_o),  64'(m_rec.err));
        cmp("rec_size", 64'(bus.rec_size_o), 64'(m_rec.size));
        cmp("rec_lat",  64'(bus.rec_lat_o),  64'(m_rec.lat));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    bus.req_i = 1'b0; bus.ack_i = 1'b0; bus.err_i = 1'b0; bus.clr_i = 1'b0;
  endtask

  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic we);
    bus.req_i = 1'b1; bus.adr_i = a; bus.d_i = d; bus.we_i = we; bus.size_i = BIU_SZ_WORD;
    bus.sp_i = a ^ 32'h5A5A_0000; bus.ra_i = d ^ 32'h0000_A5A5;
    tick();
  endtask

  task automatic do_ack(input logic [31:0] q);
    bus.ack_i = 1'b1; bus.q_i = q;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    bus.req_i = 1'b0; bus.adr_i = '0; bus.d_i = '0; bus.we_i = 1'b0; bus.size_i = BIU_SZ_BYTE;
    bus.sp_i = '0; bus.ra_i = '0; bus.ack_i = 1'b0; bus.err_i = 1'b0; bus.q_i = '0;
    bus.clr_i = 1'b0; bus.rec_ready_i = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    started = 1'b1;
    repeat (3) @(negedge clk);
    cmp("reset_outstanding", 64'(bus.outstanding_o), 64'd0);
    cmp("reset_valid",       64'(bus.rec_valid_o),   64'd0);
    rst_n = 1'b1;

    // single read, ack three cycles after the request
    do_req(32'h100, 32'h0, 1'b0);
    idle(2);
    do_ack(32'hDEAD_BEEF);
    cmp("s1_valid",     64'(bus.rec_valid_o), 64'd1);
    cmp("s1_adr",       64'(bus.rec_adr_o),   64'h100);
    cmp("s1_data",      64'(bus.rec_data_o),  64'hDEAD_BEEF);
    cmp("s1_we",        64'(bus.rec_we_o),    64'd0);
    cmp("s1_lat",       64'(bus.rec_lat_o),   64'd3);
    cmp("s1_err",       64'(bus.rec_err_o),   64'd0);
    cmp("s1_cnt_rd",    64'(bus.cnt_rd_o),    64'd1);
    cmp("s1_model_lat", 64'(m_rec.lat),       64'd3);
    idle(1);
    cmp("s1_valid_drop", 64'(bus.rec_valid_o), 64'd0);

    // four back-to-back writes, in-order acks
    for (int i = 0; i < 4; i++) do_req(32'h10 + 32'(4*i), 32'(i+1), 1'b1);
    cmp("s2_outstanding", 64'(bus.outstanding_o), 64'd4);
    for (int i = 0; i < 4; i++) begin
      do_ack(32'hFFFF_FFFF);
      cmp("s2_data", 64'(bus.rec_data_o), 64'(i+1));
      cmp("s2_adr",  64'(bus.rec_adr_o),  64'(32'h10 + 32'(4*i)));
    end
    cmp("s2_cnt_wr", 64'(bus.cnt_wr_o), 64'd4);

    // overflow then underflow
    for (int i = 0; i < 5; i++) do_req(32'h200 + 32'(4*i), 32'h0, 1'b0);
    cmp("s3_overflow",   64'(bus.overflow_o),    64'd1);
    cmp("s3_cnt_drop",   64'(bus.cnt_drop_o),    64'd1);
    cmp("s3_outstanding",64'(bus.outstanding_o), 64'd4);
    cmp("s3_model_qsize",64'(m_q.size()),        64'd4);
    for (int i = 0; i < 4; i++) begin
      do_ack(32'hA0 + 32'(i));
      cmp("s3_adr", 64'(bus.rec_adr_o), 64'(32'h200 + 32'(4*i)));
    end
    cmp("s3_no_underflow", 64'(bus.underflow_o), 64'd0);
    do_ack(32'h0);
    cmp("s3_underflow", 64'(bus.underflow_o), 64'd1);
    cmp("s3_valid",     64'(bus.rec_valid_o), 64'd0);
    cmp("s3_cnt_rd",    64'(bus.cnt_rd_o),    64'd5);

    // window edges
    do_req(32'h4000, 32'h0, 1'b0); do_ack(32'h1);
    cmp("s4_out_valid", 64'(bus.rec_valid_o), 64'd0);
    cmp("s4_out_cnt",   64'(bus.cnt_rd_o),    64'd5);
    do_req(32'h3FFC, 32'h0, 1'b0); do_ack(32'h2);
    cmp("s4_in_valid",  64'(bus.rec_valid_o), 64'd1);
    cmp("s4_in_adr",    64'(bus.rec_adr_o),   64'h3FFC);
    do_req(32'hFFFF_FFFC, 32'h0, 1'b0); do_ack(32'h3);
    cmp("s4_top_valid", 64'(bus.rec_valid_o), 64'd1);
    cmp("s4_top_adr",   64'(bus.rec_adr_o),   64'hFFFF_FFFC);
    do_req(32'hFFFF_EFFC, 32'h0, 1'b0); do_ack(32'h4);
    cmp("s4_gap_valid", 64'(bus.rec_valid_o), 64'd0);
    cmp("s4_cnt_rd",    64'(bus.cnt_rd_o),    64'd7);

    // backpressure
    bus.rec_ready_i = 1'b0;
    do_req(32'h300, 32'h0, 1'b0);
    do_req(32'h304, 32'h0, 1'b0);
    do_ack(32'h11);
    cmp("s5_valid",  64'(bus.rec_valid_o), 64'd1);
    cmp("s5_adr",    64'(bus.rec_adr_o),   64'h300);
    do_ack(32'h22);
    cmp("s5_hold_adr",  64'(bus.rec_adr_o),  64'h300);
    cmp("s5_hold_data", 64'(bus.rec_data_o), 64'h11);
    cmp("s5_cnt_drop",  64'(bus.cnt_drop_o), 64'd2);
    bus.rec_ready_i = 1'b1;
    tick();
    cmp("s5_valid_drop", 64'(bus.rec_valid_o), 64'd0);

    // ack+err together, clear, reset with pending entries
    bus.clr_i = 1'b1; tick();
    do_req(32'h20, 32'h55, 1'b1);
    bus.ack_i = 1'b1; bus.err_i = 1'b1; tick();
    cmp("s6_err",     64'(bus.rec_err_o),  64'd1);
    cmp("s6_data",    64'(bus.rec_data_o), 64'h55);
    cmp("s6_cnt_err", 64'(bus.cnt_err_o),  64'd1);
    cmp("s6_cnt_wr",  64'(bus.cnt_wr_o),   64'd0);
    bus.clr_i = 1'b1; tick();
    cmp("s6_clr_err",  64'(bus.cnt_err_o),   64'd0);
    cmp("s6_clr_rd",   64'(bus.cnt_rd_o),    64'd0);
    cmp("s6_clr_drop", 64'(bus.cnt_drop_o),  64'd0);
    cmp("s6_clr_ovf",  64'(bus.overflow_o),  64'd0);
    cmp("s6_clr_unf",  64'(bus.underflow_o), 64'd0);
    do_req(32'h40, 32'h0, 1'b0);
    do_req(32'h44, 32'h0, 1'b0);
    cmp("s6_pending", 64'(bus.outstanding_o), 64'd2);
    rst_n = 1'b0;
    @(negedge clk);
    cmp("s6_rst_outstanding", 64'(bus.outstanding_o), 64'd0);
    rst_n = 1'b1;
    do_ack(32'h7); do_ack(32'h8);
    cmp("s6_rst_norec", 64'(bus.rec_valid_o), 64'd0);
    cmp("s6_rst_unf",   64'(bus.underflow_o), 64'd1);

    // random traffic; 4-bit counters saturate along the way
    for (int n = 0; n < 4000; n++) begin
      int unsigned sel;
      bus.req_i = ($urandom_range(99) < 35);
      sel = $urandom_range(3);
      case (sel)
        0:       bus.adr_i = 32'($urandom_range(32'h3FFF)) & 32'hFFFF_FFFC;
        1:       bus.adr_i = 32'h4000 + (32'($urandom_range(255)) & 32'hFC);
        2:       bus.adr_i = 32'hFFFF_F000 + (32'($urandom_range(32'hFFF)) & 32'hFFC);
        default: bus.adr_i = $urandom;
      endcase
      bus.d_i = $urandom; bus.we_i = $urandom_range(1) == 1;
      bus.size_i = biu_size_t'($urandom_range(3));
      bus.sp_i = $urandom; bus.ra_i = $urandom; bus.q_i = $urandom;
      if ($urandom_range(99) < 35) begin
        sel = $urandom_range(9);
        bus.ack_i = (sel != 0);
        bus.err_i = (sel < 3);
      end else begin
        bus.ack_i = 1'b0; bus.err_i = 1'b0;
      end
      bus.rec_ready_i = $urandom_range(3) != 0;
      bus.clr_i = $urandom_range(299) == 0;
      rst_n = $urandom_range(1499) != 0;
      @(negedge clk);
    end
    rst_n = 1'b1; bus.rec_ready_i = 1'b1;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
